gate_test_seq: RTL and testbench
================================

GATE_TEST_SEQ -- requirements
Module: gate_test_seq

Interface
REQ-001 SHALL have parameter SETTLE_W, default 4, width of the settle-cycle count.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request one full self-test sweep, sampled in IDLE only.
REQ-005 SHALL have port settle_cycles  input  SETTLE_W  wait cycles after each vector; 0 treated as 1; latched at accepted start.
REQ-006 SHALL have port in1  output  1  operand A driven to gates datapath.
REQ-007 SHALL have port in2  output  1  operand B driven to gates datapath.
REQ-008 SHALL have port gate_out  input  7  datapath results, bit order [6:0] = {xnor, xor, nor, nand, or, and, not}.
REQ-009 SHALL have port busy  output  1  high from the cycle after accepted start through the DONE cycle.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port pass  output  1  high when the last sweep had zero mismatches.
REQ-012 SHALL have port fail_mask  output  4  bit k set if vector k mismatched in any gate.
REQ-013 SHALL have port fail_gates  output  7  OR over all vectors of per-gate mismatch bits, same order as gate_out.
REQ-014 SHALL have port vec_idx  output  2  index of the vector currently applied.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, CAPTURE, DONE.
REQ-016 Vector k SHALL drive {in1,in2} = k[1:0], i.e. 00, 01, 10, 11 for k = 0..3.
REQ-017 IDLE with start=1 SHALL go next cycle to SETTLE, with vec_idx=0, vector 0 driven, counter=max(settle_cycles,1), and fail_mask, fail_gates and pass cleared.
REQ-018 SETTLE SHALL decrement the counter each cycle and go to CAPTURE on the cycle after counter==1, so SETTLE lasts exactly S cycles.
REQ-019 CAPTURE SHALL compare gate_out with the expected value: not=~in1, and, or, nand, nor, xor, xnor of in1,in2.
REQ-020 CAPTURE SHALL OR the mismatch bits into fail_gates and set fail_mask[vec_idx] if any bit differs.
REQ-021 CAPTURE with vec_idx<3 SHALL increment vec_idx, drive the next vector, reload the counter and return to SETTLE.
REQ-022 CAPTURE with vec_idx==3 SHALL go to DONE.
REQ-023 DONE SHALL assert done for one cycle, set pass=(fail_mask==0) including the final capture, then return to IDLE.
REQ-024 Latency SHALL be done high exactly 4*(S+1)+1 cycles after the start-sampling edge, for effective settle count S.
REQ-025 start while busy SHALL be ignored; a change in settle_cycles mid-sweep SHALL have no effect.
REQ-026 start=1 in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-027 pass, fail_mask and fail_gates SHALL hold their values from DONE until the next accepted start.
REQ-028 In IDLE, in1, in2 and vec_idx SHALL be 0.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, in1=in2=0, vec_idx=0, busy=0, done=0, pass=0, fail_mask=0, fail_gates=0, counter=0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; the first start after release SHALL run a full sweep from vector 0.

Structure
REQ-031 Package gates_pkg SHALL hold the state encodings, the gate bit-index constants (GATE_NOT=0 .. GATE_XNOR=6) and the vector count (4).
REQ-032 The expected-result generator SHALL be a combinational sub-module, gates_golden, with inputs in1, in2 and a 7-bit expected output.
REQ-033 The FSM, counter and result registers SHALL reside in gate_test_seq.

Verification
REQ-034 Correct gates model, settle_cycles=2, start pulse at cycle 0 -> done at cycle 13, pass=1, fail_mask=0000, fail_gates=0000000.
REQ-035 Model with AND stuck-at-1 -> fail_mask=0111, fail_gates=0000010, pass=0.
REQ-036 settle_cycles=0 -> behaves as S=1, done at cycle 9; in1/in2 sequence 00, 01, 10, 11, each held 2 cycles.
REQ-037 Second start during busy, and settle_cycles changed to 7 mid-sweep -> single done pulse, timing unchanged.
REQ-038 rst_n pulsed low in vector 2 SETTLE -> all outputs zero immediately, no done pulse; new start -> full clean sweep, pass=1.
REQ-039 Back-to-back: start high through DONE and the following cycle -> second sweep accepted only in IDLE, results cleared at its start.

Source files
------------

// File: rtl/gates_pkg.sv
// Shared definitions for the logic-gate self-test sequencer: FSM states,
// gate bit positions within the 7-bit result word, and the vector count.
package gates_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int GATE_NOT  = 0;
  localparam int GATE_AND  = 1;
  localparam int GATE_OR   = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  localparam int NUM_GATES = 7;
  localparam int NUM_VECS  = 4;

endpackage

// File: rtl/gates_golden.sv
// Combinational reference for the gates datapath: the result word a correct
// datapath must return for operands in1/in2.
module gates_golden
  import gates_pkg::*;
(
  input  logic                 in1,
  input  logic                 in2,
  output logic [NUM_GATES-1:0] expected
);

  always_comb begin
    expected            = '0;
    expected[GATE_NOT]  = ~in1;
    expected[GATE_AND]  = in1 & in2;
    expected[GATE_OR]   = in1 | in2;
    expected[GATE_NAND] = ~(in1 & in2);
    expected[GATE_NOR]  = ~(in1 | in2);
    expected[GATE_XOR]  = in1 ^ in2;
    expected[GATE_XNOR] = ~(in1 ^ in2);
  end

endmodule

// File: rtl/gate_test_seq.sv
// Self-test sequencer: sweeps the four operand pairs through an external gates
// datapath, waits a programmable settle time per vector, and accumulates mismatches.
module gate_test_seq
  import gates_pkg::*;
#(
  parameter int SETTLE_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SETTLE_W-1:0]  settle_cycles,
  output logic                 in1,
  output logic                 in2,
  input  logic [NUM_GATES-1:0] gate_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_VECS-1:0]  fail_mask,
  output logic [NUM_GATES-1:0] fail_gates,
  output logic [1:0]           vec_idx,
  output logic [1:0]           dbg_state
);

  // Handshake: start is a level sampled only in IDLE; once accepted, busy is high
  // until the one-cycle done pulse, and results stay valid until the next accepted start.

  localparam logic [SETTLE_W-1:0] CNT_ONE  = SETTLE_W'(1);
  localparam logic [1:0]          LAST_VEC = 2'(NUM_VECS - 1);

  state_e                 state_q,  state_d;
  logic [SETTLE_W-1:0]    cnt_q,    cnt_d;
  logic [SETTLE_W-1:0]    settle_q, settle_d;
  logic [1:0]             vec_q,    vec_d;
  logic                   pass_q,   pass_d;
  logic [NUM_VECS-1:0]    fmask_q,  fmask_d;
  logic [NUM_GATES-1:0]   fgates_q, fgates_d;

  logic [NUM_GATES-1:0]   expected;
  logic [NUM_GATES-1:0]   mismatch;
  logic [SETTLE_W-1:0]    settle_eff;

  gates_golden u_golden (
    .in1      (vec_q[1]),
    .in2      (vec_q[0]),
    .expected (expected)
  );

  assign mismatch   = gate_out ^ expected;
  assign settle_eff = (settle_cycles == '0) ? CNT_ONE : settle_cycles;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    pass_d   = pass_q;
    fmask_d  = fmask_q;
    fgates_d = fgates_q;
    unique case (state_q)
      ST_IDLE: begin
        vec_d = '0;
        if (start) begin
          state_d  = ST_SETTLE;
          cnt_d    = settle_eff;
          settle_d = settle_eff;
          pass_d   = 1'b0;
          fmask_d  = '0;
          fgates_d = '0;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        fgates_d = fgates_q | mismatch;
        if (|mismatch) begin
          fmask_d[vec_q] = 1'b1;
        end
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
          vec_d   = '0;
          // Verdict includes the capture happening on this same edge.
          pass_d  = (fmask_d == '0);
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + 2'd1;
          cnt_d   = settle_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
      vec_q    <= '0;
      pass_q   <= 1'b0;
      fmask_q  <= '0;
      fgates_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      pass_q   <= pass_d;
      fmask_q  <= fmask_d;
      fgates_q <= fgates_d;
    end
  end

  assign in1        = vec_q[1];
  assign in2        = vec_q[0];
  assign vec_idx    = vec_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign fail_mask  = fmask_q;
  assign fail_gates = fgates_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_gate_test_seq.sv
// Bench for gate_test_seq: a faultable gates datapath model feeds the DUT; sweep
// results and timing are checked against a table plus a truth-table reference model.
module tb_gate_test_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] settle_cycles = '0;
  logic       in1, in2;
  logic [6:0] gate_out;
  logic       busy, done, pass;
  logic [3:0] fail_mask;
  logic [6:0] fail_gates;
  logic [1:0] vec_idx;
  logic [1:0] dbg_state;

  logic [6:0] sa1_r = '0;
  logic [6:0] sa0_r = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] exp_q[$];

  typedef struct {
    int         settle;
    logic [6:0] sa1;
    logic [6:0] sa0;
    logic [3:0] efm;
    logic [6:0] efg;
    logic       ep;
    int         elat;
    bit         extra;
  } vec_t;

  vec_t tbl[6];

  gate_test_seq #(.SETTLE_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .settle_cycles (settle_cycles),
    .in1           (in1),
    .in2           (in2),
    .gate_out      (gate_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_mask     (fail_mask),
    .fail_gates    (fail_gates),
    .vec_idx       (vec_idx),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  // Truth table by arithmetic on operand values: {xnor,xor,nor,nand,or,and,not}.
  function automatic logic [6:0] gate_truth(input logic a, input logic b);
    int ia, ib;
    logic [6:0] r;
    ia = int'(a);
    ib = int'(b);
    r[0] = (ia == 0);
    r[1] = (ia * ib == 1);
    r[2] = (ia + ib > 0);
    r[3] = (ia * ib == 0);
    r[4] = (ia + ib == 0);
    r[5] = (ia + ib == 1);
    r[6] = (ia == ib);
    return r;
  endfunction

  assign gate_out = (gate_truth(in1, in2) & ~sa0_r) | sa1_r;

  task automatic ref_sweep(input logic [6:0] sa1, input logic [6:0] sa0,
                           output logic [3:0] fm, output logic [6:0] fg, output logic ps);
    logic [6:0] good, diff;
    fm = '0;
    fg = '0;
    for (int k = 0; k < 4; k++) begin
      good = gate_truth(logic'(k / 2), logic'(k % 2));
      diff = ((good & ~sa0) | sa1) ^ good;
      if (diff != 0) fm[k] = 1'b1;
      fg = fg | diff;
    end
    ps = (fm == 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_sweep(input string tag, input int s, input logic [6:0] sa1,
                           input logic [6:0] sa0, input logic [3:0] efm,
                           input logic [6:0] efg, input logic ep, input int elat,
                           input bit extra);
    int  n, eff, seq_err;
    bit  got_done;
    logic [1:0] e;
    eff = (s == 0) ? 1 : s;
    exp_q.delete();
    for (int k = 0; k < 4; k++)
      for (int r = 0; r < eff + 1; r++) exp_q.push_back(2'(k));
    n = 0;
    seq_err = 0;
    got_done = 0;
    @(negedge clk);
    sa1_r = sa1;
    sa0_r = sa0;
    settle_cycles = 4'(s);
    start = 1'b1;
    while (!got_done && n < 200) begin
      @(negedge clk);
      n++;
      if (!extra && n == 1) start = 1'b0;
      if (extra && n == 4) settle_cycles = 4'd7;
      if (extra && n == 6) start = 1'b0;
      if (done) begin
        got_done = 1;
      end else if (exp_q.size() == 0) begin
        seq_err++;
      end else begin
        e = exp_q.pop_front();
        if ({in1, in2} !== e || vec_idx !== e || busy !== 1'b1) seq_err++;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(elat));
    check({tag, "_vec_seq"}, 32'(seq_err), 32'd0);
    check({tag, "_fail_mask"}, 32'(fail_mask), 32'(efm));
    check({tag, "_fail_gates"}, 32'(fail_gates), 32'(efg));
    check({tag, "_pass"}, 32'(pass), 32'(ep));
    @(negedge clk);
    check({tag, "_idle_after"}, {27'd0, done, busy, in1, in2, |vec_idx}, 32'd0);
    check({tag, "_hold"}, {20'd0, pass, fail_mask, fail_gates}, {20'd0, ep, efm, efg});
  endtask

  initial begin
    int s, n;
    bit saw_done;
    logic [6:0] rsa1, rsa0, efg;
    logic [3:0] efm;
    logic ep;

    tbl[0] = '{settle: 2,  sa1: 7'h00, sa0: 7'h00, efm: 4'b0000, efg: 7'b0000000, ep: 1'b1, elat: 13, extra: 0};
    tbl[1] = '{settle: 2,  sa1: 7'h02, sa0: 7'h00, efm: 4'b0111, efg: 7'b0000010, ep: 1'b0, elat: 13, extra: 0};
    tbl[2] = '{settle: 0,  sa1: 7'h00, sa0: 7'h00, efm: 4'b0000, efg: 7'b0000000, ep: 1'b1, elat: 9,  extra: 0};
    tbl[3] = '{settle: 3,  sa1: 7'h00, sa0: 7'h00, efm: 4'b0000, efg: 7'b0000000, ep: 1'b1, elat: 17, extra: 1};
    tbl[4] = '{settle: 1,  sa1: 7'h00, sa0: 7'h20, efm: 4'b0110, efg: 7'b0100000, ep: 1'b0, elat: 9,  extra: 0};
    tbl[5] = '{settle: 15, sa1: 7'h01, sa0: 7'h00, efm: 4'b1100, efg: 7'b0000001, ep: 1'b0, elat: 65, extra: 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {19'd0, in1, in2, vec_idx, busy, done, pass, fail_mask, fail_gates}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 6; i++)
      run_sweep($sformatf("tbl%0d", i), tbl[i].settle, tbl[i].sa1, tbl[i].sa0,
                tbl[i].efm, tbl[i].efg, tbl[i].ep, tbl[i].elat, tbl[i].extra);

    // Reset during vector-2 settle, with partial failures already recorded
    @(negedge clk);
    sa1_r = 7'h02;
    sa0_r = 7'h00;
    settle_cycles = 4'd2;
    start = 1'b1;
    n = 0;
    while (n < 7) begin
      @(negedge clk);
      n++;
      start = 1'b0;
    end
    check("pre_reset_vec", 32'(vec_idx), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {19'd0, in1, in2, vec_idx, busy, done, pass, fail_mask, fail_gates}, 32'd0);
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("midreset_no_done", 32'(saw_done), 32'd0);
    run_sweep("post_reset", 2, 7'h00, 7'h00, 4'b0000, 7'b0000000, 1'b1, 13, 0);

    // Back-to-back: start held high through DONE and the following IDLE cycle
    @(negedge clk);
    sa1_r = 7'h02;
    sa0_r = 7'h00;
    settle_cycles = 4'd1;
    start = 1'b1;
    n = 0;
    saw_done = 0;
    while (!saw_done && n < 200) begin
      @(negedge clk);
      n++;
      if (done) saw_done = 1;
    end
    check("b2b_first_latency", 32'(n), 32'd9);
    check("b2b_first_mask", 32'(fail_mask), 32'b0111);
    @(negedge clk);
    check("b2b_idle_gap", {29'd0, busy, done, pass}, 32'd0);
    check("b2b_idle_hold", 32'(fail_mask), 32'b0111);
    sa1_r = 7'h00;
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_cleared", {20'd0, busy, pass, fail_mask, fail_gates}, {20'd0, 1'b1, 1'b0, 4'd0, 7'd0});
    n = 1;
    saw_done = 0;
    while (!saw_done && n < 200) begin
      @(negedge clk);
      n++;
      if (done) saw_done = 1;
    end
    check("b2b_second_latency", 32'(n), 32'd9);
    check("b2b_second_pass", 32'(pass), 32'd1);

    // Randomized sweeps against the truth-table reference model
    for (int i = 0; i < 8; i++) begin
      s = $urandom_range(0, 6);
      rsa1 = 7'($urandom_range(0, 127)) & 7'($urandom_range(0, 127)) & 7'($urandom_range(0, 127));
      rsa0 = 7'($urandom_range(0, 127)) & 7'($urandom_range(0, 127)) & ~rsa1;
      ref_sweep(rsa1, rsa0, efm, efg, ep);
      run_sweep($sformatf("rand%0d", i), s, rsa1, rsa0, efm, efg, ep,
                4 * (((s == 0) ? 1 : s) + 1) + 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
